// File: rtl/demosaic_pkg.sv
// Shared constants and helpers for the demosaic front end: kernel geometry,
// Bayer phase encoding, clamping and window bit packing.
package demosaic_pkg;

    localparam int DW    = 10;
    localparam int KSIZE = 7;
    localparam int KHALF = 3;

    typedef enum logic [1:0] {
        PH_R  = 2'd0,
        PH_GR = 2'd1,
        PH_GB = 2'd2,
        PH_B  = 2'd3
    } bayer_phase_t;

    localparam logic [1:0] ORDER_GRBG = 2'd0;
    localparam logic [1:0] ORDER_RGGB = 2'd1;
    localparam logic [1:0] ORDER_BGGR = 2'd2;
    localparam logic [1:0] ORDER_GBRG = 2'd3;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Flat element index of window row k, column j.
    function automatic int win_idx(input int k, input int j);
        return k * KSIZE + j;
    endfunction

    // RGGB is the reference tiling; other orders are that tiling shifted by one
    // pixel horizontally and/or vertically, i.e. an XOR on {y0, x0}.
    function automatic bayer_phase_t bayer_phase(input logic x0, input logic y0,
                                                 input logic [1:0] order);
        logic [1:0] offs;
        case (order)
            ORDER_GRBG: offs = 2'b01;
            ORDER_RGGB: offs = 2'b00;
            ORDER_BGGR: offs = 2'b11;
            default:    offs = 2'b10;
        endcase
        return bayer_phase_t'({y0, x0} ^ offs);
    endfunction

endpackage

// File: rtl/win_row_clamp.sv
// Selects, for one window row, the vertical tap that holds the clamped image
// row, across all seven window columns.
module win_row_clamp
    import demosaic_pkg::KSIZE;
    import demosaic_pkg::clamp;
#(
    parameter int DW       = 10,
    parameter int V_ACTIVE = 480,
    parameter int ROW      = 0
) (
    input  logic [13:0]               line,
    input  logic [KSIZE*KSIZE*DW-1:0] cols,
    output logic [KSIZE*DW-1:0]       row
);

    logic [2:0] sel;

    // In input line n, tap t carries image row n-6+t.
    always_comb begin
        int top;
        int src;
        top = int'(line) - (KSIZE - 1);
        src = clamp(top + ROW, 0, V_ACTIVE - 1) - top;
        sel = 3'(clamp(src, 0, KSIZE - 1));
    end

    always_comb begin
        row = '0;
        for (int j = 0; j < KSIZE; j++)
            row[j*DW +: DW] = cols[(KSIZE*j + int'(sel))*DW +: DW];
    end

endmodule

// File: rtl/bayer_window_7x7.sv
// 7x7 Bayer neighbourhood generator: column shift window with edge replication
// on all four borders, followed by a registered vertical clamp stage.
module bayer_window_7x7
    import demosaic_pkg::KSIZE;
    import demosaic_pkg::KHALF;
    import demosaic_pkg::win_idx;
    import demosaic_pkg::bayer_phase;
#(
    parameter int DW          = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BAYER_ORDER = 0
) (
    input  logic                      VGA_CLK,
    input  logic                      iRST_N,
    input  logic                      iFVAL,
    input  logic                      iDVAL,
    input  logic [DW-1:0]             taps0x,
    input  logic [DW-1:0]             taps1x,
    input  logic [DW-1:0]             taps2x,
    input  logic [DW-1:0]             taps3x,
    input  logic [DW-1:0]             taps4x,
    input  logic [DW-1:0]             taps5x,
    input  logic [DW-1:0]             taps6x,
    output logic [KSIZE*KSIZE*DW-1:0] oWIN,
    output logic                      oDVAL,
    output logic [12:0]               oX,
    output logic [12:0]               oY,
    output logic [1:0]                oBAYER,
    output logic                      oERR
);

    localparam logic [12:0] H_LAST    = 13'(H_ACTIVE - 1);
    localparam logic [13:0] LAST_LINE = 14'(V_ACTIVE + KHALF - 1);

    logic [DW-1:0] tap_in [KSIZE];
    logic [DW-1:0] s      [KSIZE][KSIZE];
    logic          fval_q, fval_rise, err;
    logic [12:0]   col, col_e, x1;
    logic [13:0]   line, line_e, ln1;
    logic [1:0]    flush, flush_e;
    logic          err_e, v1;

    assign tap_in[0] = taps0x;
    assign tap_in[1] = taps1x;
    assign tap_in[2] = taps2x;
    assign tap_in[3] = taps3x;
    assign tap_in[4] = taps4x;
    assign tap_in[5] = taps5x;
    assign tap_in[6] = taps6x;

    // A frame start clears the counters before this cycle's pixel is looked at,
    // so a pixel arriving with the rising edge becomes column 0 of line 0.
    assign fval_rise = iFVAL & ~fval_q;
    assign col_e     = fval_rise ? '0 : col;
    assign line_e    = fval_rise ? '0 : line;
    assign flush_e   = fval_rise ? '0 : flush;
    assign err_e     = fval_rise ? 1'b0 : err;

    always_ff @(posedge VGA_CLK) begin
        if (!iRST_N) begin
            fval_q <= 1'b0;
            col    <= '0;
            line   <= '0;
            flush  <= '0;
            err    <= 1'b0;
            v1     <= 1'b0;
            x1     <= '0;
            ln1    <= '0;
            for (int i = 0; i < KSIZE; i++)
                for (int t = 0; t < KSIZE; t++)
                    s[i][t] <= '0;
        end else begin
            fval_q <= iFVAL;
            col    <= col_e;
            line   <= line_e;
            flush  <= flush_e;
            err    <= err_e;
            v1     <= 1'b0;
            if (flush_e != 2'd0) begin
                // Right-edge replication: S6 stays put while the rest shift.
                for (int i = 0; i < KSIZE - 1; i++)
                    for (int t = 0; t < KSIZE; t++)
                        s[i][t] <= s[i+1][t];
                flush <= flush_e - 2'd1;
                x1    <= 13'(H_ACTIVE) - {11'd0, flush_e};
                ln1   <= line_e - 14'd1;
                v1    <= (line_e - 14'd1) >= 14'(KHALF);
                if (iDVAL)
                    err <= 1'b1;
            end else if (iDVAL && line_e <= LAST_LINE) begin
                for (int t = 0; t < KSIZE; t++) begin
                    for (int i = 0; i < KSIZE - 1; i++)
                        s[i][t] <= (col_e == '0) ? tap_in[t] : s[i+1][t];
                    s[KSIZE-1][t] <= tap_in[t];
                end
                if (col_e == H_LAST) begin
                    col   <= '0;
                    line  <= line_e + 14'd1;
                    flush <= 2'(KHALF);
                end else begin
                    col <= col_e + 13'd1;
                end
                x1  <= col_e - 13'(KHALF);
                ln1 <= line_e;
                v1  <= (col_e >= 13'(KHALF)) && (line_e >= 14'(KHALF));
            end
        end
    end

    logic [KSIZE*KSIZE*DW-1:0] win_cols, win_next;
    logic [KSIZE*DW-1:0]       win_rows [KSIZE];
    logic [12:0]               y_c;

    always_comb begin
        win_cols = '0;
        for (int j = 0; j < KSIZE; j++)
            for (int t = 0; t < KSIZE; t++)
                win_cols[(KSIZE*j + t)*DW +: DW] = s[j][t];
    end

    for (genvar k = 0; k < KSIZE; k++) begin : g_row
        win_row_clamp #(
            .DW       (DW),
            .V_ACTIVE (V_ACTIVE),
            .ROW      (k)
        ) u_row (
            .line (ln1),
            .cols (win_cols),
            .row  (win_rows[k])
        );
    end

    always_comb begin
        win_next = '0;
        for (int k = 0; k < KSIZE; k++)
            win_next[win_idx(k, 0)*DW +: KSIZE*DW] = win_rows[k];
    end

    assign y_c = 13'(ln1 - 14'(KHALF));

    always_ff @(posedge VGA_CLK) begin
        if (!iRST_N) begin
            oWIN   <= '0;
            oDVAL  <= 1'b0;
            oX     <= '0;
            oY     <= '0;
            oBAYER <= '0;
        end else begin
            oDVAL <= v1;
            if (v1) begin
                oWIN   <= win_next;
                oX     <= x1;
                oY     <= y_c;
                oBAYER <= bayer_phase(x1[0], y_c[0], 2'(BAYER_ORDER));
            end
        end
    end

    assign oERR = err;

endmodule

// File: tb/tb_bayer_window_7x7.sv
// Directed bench for bayer_window_7x7 on an 8x6 ramp image (pixel = 16*row+col)
// with a scoreboard of expected windows; two instances cover two Bayer orders.
module tb_bayer_window_7x7;

    localparam int DW = 10;
    localparam int H  = 8;
    localparam int V  = 6;
    localparam int NL = V + 3;
    localparam int WW = 49 * DW;

    typedef struct packed {
        logic [WW-1:0] win;
        logic [12:0]   x;
        logic [12:0]   y;
        logic [1:0]    b1;
        logic [1:0]    b0;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fval = 1'b0;
    logic          dval = 1'b0;
    logic [DW-1:0] tap [7];

    logic [WW-1:0] win1, win0;
    logic          dval1, dval0, err1, err0;
    logic [12:0]   x1, y1, x0, y0;
    logic [1:0]    bay1, bay0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int first_seen = 0;
    int first_cyc = 0;
    int sample_cyc = 0;
    logic [WW-1:0] cap43, cap00, cap75;
    logic [1:0]    capb1 [4];
    logic [1:0]    capb0;

    bayer_window_7x7 #(.DW(DW), .H_ACTIVE(H), .V_ACTIVE(V), .BAYER_ORDER(1)) dut (
        .VGA_CLK(clk), .iRST_N(rst_n), .iFVAL(fval), .iDVAL(dval),
        .taps0x(tap[0]), .taps1x(tap[1]), .taps2x(tap[2]), .taps3x(tap[3]),
        .taps4x(tap[4]), .taps5x(tap[5]), .taps6x(tap[6]),
        .oWIN(win1), .oDVAL(dval1), .oX(x1), .oY(y1), .oBAYER(bay1), .oERR(err1)
    );

    bayer_window_7x7 #(.DW(DW), .H_ACTIVE(H), .V_ACTIVE(V), .BAYER_ORDER(0)) dut0 (
        .VGA_CLK(clk), .iRST_N(rst_n), .iFVAL(fval), .iDVAL(dval),
        .taps0x(tap[0]), .taps1x(tap[1]), .taps2x(tap[2]), .taps3x(tap[3]),
        .taps4x(tap[4]), .taps5x(tap[5]), .taps6x(tap[6]),
        .oWIN(win0), .oDVAL(dval0), .oX(x0), .oY(y0), .oBAYER(bay0), .oERR(err0)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // reference model
    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [WW-1:0] exp_window(input int x, input int y);
        logic [WW-1:0] w = '0;
        for (int k = 0; k < 7; k++)
            for (int j = 0; j < 7; j++)
                w[(7*k + j)*DW +: DW] =
                    DW'(16 * clampi(y - 3 + k, 0, V - 1) + clampi(x - 3 + j, 0, H - 1));
        return w;
    endfunction

    // RGGB: R Gr / Gb B
    function automatic logic [1:0] phase_rggb(input int x, input int y);
        case ({y[0], x[0]})
            2'b00: return 2'd0;
            2'b01: return 2'd1;
            2'b10: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // GRBG: Gr R / B Gb
    function automatic logic [1:0] phase_grbg(input int x, input int y);
        case ({y[0], x[0]})
            2'b00: return 2'd1;
            2'b01: return 2'd0;
            2'b10: return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    task automatic push_exp(input int x, input int y);
        exp_t n;
        n.win = exp_window(x, y);
        n.x   = 13'(x);
        n.y   = 13'(y);
        n.b1  = phase_rggb(x, y);
        n.b0  = phase_grbg(x, y);
        exp_q.push_back(n);
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (dval1 === 1'b1 || dval0 === 1'b1)
            chk("dval_pair", dval0, dval1);
        if (dval1 === 1'b1) begin
            pulse_cnt++;
            if (first_seen == 0) begin
                first_seen = 1;
                first_cyc  = cyc;
            end
            if (x1 == 13'd4 && y1 == 13'd3) cap43 = win1;
            if (x1 == 13'd0 && y1 == 13'd0) begin
                cap00 = win1;
                capb0 = bay0;
            end
            if (x1 == 13'd7 && y1 == 13'd5) cap75 = win1;
            if (x1 < 13'd2 && y1 < 13'd2) capb1[2*y1[0] + x1[0]] = bay1;
            if (exp_q.size() == 0) begin
                chk("unexpected_dval", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_x", x1, e.x);
                chk("sb_y", y1, e.y);
                chk("sb_win", win1, e.win);
                chk("sb_bayer_rggb", bay1, e.b1);
                chk("sb_x0", x0, e.x);
                chk("sb_y0", y0, e.y);
                chk("sb_win0", win0, e.win);
                chk("sb_bayer_grbg", bay0, e.b0);
            end
        end
    end

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_taps(input int n, input int c);
        for (int j = 0; j < 7; j++) begin
            int r;
            r = n - 6 + j;
            tap[j] = (r >= 0 && r < V) ? DW'(16 * r + c) : DW'($urandom_range(1023, 0));
        end
    endtask

    task automatic rand_taps();
        for (int j = 0; j < 7; j++) tap[j] = DW'($urandom_range(1023, 0));
    endtask

    // mode 0: plain line; 1: stray iDVAL on the 2nd flush cycle; 2: reset there
    task automatic drive_line(input int n, input int mode);
        for (int c = 0; c < H; c++) begin
            set_taps(n, c);
            dval = 1'b1;
            if (c >= 3 && n >= 3 && n <= V + 2) push_exp(c - 3, n - 3);
            tick();
            if (n == 3 && c == 3) sample_cyc = cyc;
        end
        dval = 1'b0;
        rand_taps();
        if (n >= 3 && n <= V + 2)
            for (int x = H - 3; x < H; x++) push_exp(x, n - 3);
        tick();
        if (mode == 2) begin
            rst_n = 1'b0;
            tick();
            chk("rst_pending", exp_q.size(), 3);
            chk("rst_win", win1, '0);
            chk("rst_dval", dval1, 1'b0);
            chk("rst_x", x1, '0);
            chk("rst_y", y1, '0);
            chk("rst_bayer", bay1, '0);
            chk("rst_err", err1, 1'b0);
            chk("rst_dval0", dval0, 1'b0);
            exp_q.delete();
            rst_n = 1'b1;
            return;
        end
        if (mode == 1) begin
            dval = 1'b1;
            rand_taps();
        end
        tick();
        dval = 1'b0;
        tick();
    endtask

    task automatic run_frame(input int simul, input int err_line, input int rst_line);
        pulse_cnt  = 0;
        first_seen = 0;
        first_cyc  = 0;
        cap43 = 'x;
        cap00 = 'x;
        cap75 = 'x;
        capb0 = 'x;
        for (int i = 0; i < 4; i++) capb1[i] = 'x;
        if (simul == 0) begin
            fval = 1'b1;
            tick();
            chk("err_clear", err1, 1'b0);
            chk("err_clear0", err0, 1'b0);
        end
        for (int n = 0; n < NL; n++) begin
            fval = 1'b1;
            drive_line(n, (n == err_line) ? 1 : ((n == rst_line) ? 2 : 0));
            if (n == rst_line) return;
        end
        tick();
        tick();
        tick();
        chk("frame_count", pulse_cnt, H * V);
        chk("queue_empty", exp_q.size(), 0);
        chk("first_latency", first_cyc, sample_cyc + 1);
    endtask

    task automatic check_caps();
        logic [WW-1:0] w43, w00, w75;
        w43 = '0;
        w00 = '0;
        w75 = '0;
        for (int k = 0; k < 7; k++)
            for (int j = 0; j < 7; j++) begin
                w43[(7*k + j)*DW +: DW] = DW'(16 * ((k > 5) ? 5 : k) + 1 + j);
                w00[(7*k + j)*DW +: DW] = DW'(16 * ((k < 3) ? 0 : k - 3) + ((j < 3) ? 0 : j - 3));
                w75[(7*k + j)*DW +: DW] = DW'(16 * ((k + 2 > 5) ? 5 : k + 2) + ((j + 4 > 7) ? 7 : j + 4));
            end
        chk("interior_4_3", cap43, w43);
        chk("corner_0_0", cap00, w00);
        chk("corner_7_5", cap75, w75);
        chk("bayer_rggb_0_0", capb1[0], 2'd0);
        chk("bayer_rggb_1_0", capb1[1], 2'd1);
        chk("bayer_rggb_0_1", capb1[2], 2'd2);
        chk("bayer_rggb_1_1", capb1[3], 2'd3);
        chk("bayer_grbg_0_0", capb0, 2'd1);
    endtask

    initial begin
        rand_taps();
        tick();
        tick();
        chk("reset_win", win1, '0);
        chk("reset_dval", dval1, 1'b0);
        chk("reset_x", x1, '0);
        chk("reset_y", y1, '0);
        chk("reset_bayer", bay1, '0);
        chk("reset_err", err1, 1'b0);
        rst_n = 1'b1;
        tick();

        // frame A: plain frame
        run_frame(0, -1, -1);
        check_caps();
        chk("err_idle", err1, 1'b0);
        fval = 1'b0;
        tick();
        tick();

        // frame B: iFVAL rises with the first pixel; stray iDVAL after line 4
        run_frame(1, 4, -1);
        check_caps();
        chk("err_set", err1, 1'b1);
        fval = 1'b0;
        tick();
        tick();
        chk("err_sticky", err1, 1'b1);
        chk("err_sticky0", err0, 1'b1);

        // frame C: reset during the flush of line 5
        run_frame(0, -1, 5);
        fval = 1'b0;
        tick();
        tick();

        // frame D: must match frame A after the reset
        run_frame(0, -1, -1);
        check_caps();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
